param_assoc_cache: RTL

Parametrised set-associative, write-back, write-allocate cache. Next generation of the team's fixed-geometry cache, generalised in sets, ways and line size, with an added flush operation. Sits between the CPU-side memory port (mem_*) and physical memory (pmem_*) and uses the same request/response handshake on both sides.

---
 rtl/param_assoc_cache.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/param_assoc_cache.sv
// Parametrised set-associative write-back/write-allocate cache with round-robin
// replacement and a scan-based flush that writes back every dirty line.
module param_assoc_cache #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 8,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [ADDR_W-1:0]        mem_address,
    input  logic [31:0]              mem_wdata,
    input  logic [3:0]               mem_byte_enable,
    output logic [31:0]              mem_rdata,
    output logic                     mem_resp,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic [32*LINE_WORDS-1:0] pmem_wdata,
    input  logic [32*LINE_WORDS-1:0] pmem_rdata,
    input  logic                     pmem_resp,
    input  logic                     flush_i,
    output logic                     flush_done_o
);

    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        TAG_CHECK,
        WRITEBACK,
        FILL,
        FLUSH_SCAN,
        FLUSH_WB
    } state_t;

    state_t state;

    logic [LINE_W-1:0] data_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic              valid_q [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    logic [WAY_W-1:0]  rr_ptr  [SETS];

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              write_q;
    logic [WAY_W-1:0]  victim_q;
    logic [IDX_W-1:0]  scan_set;
    logic [WAY_W-1:0]  scan_way;
    logic [31:0]       rdata_q;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] req_word;
    logic              unused_lsbs;

    assign req_idx     = addr_q[OFF_W +: IDX_W];
    assign req_tag     = addr_q[ADDR_W-1 -: TAG_W];
    assign req_word    = addr_q[2 +: WSEL_W];
    assign unused_lsbs = ^addr_q[1:0];

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              victim_found;
    logic [WAY_W-1:0]  victim_way;
    logic [LINE_W-1:0] hit_line;
    logic [31:0]       hit_word;
    logic [31:0]       merged_word;
    logic [WAY_W-1:0]  rr_next;
    logic              scan_last;
    logic [IDX_W-1:0]  scan_set_next;
    logic [WAY_W-1:0]  scan_way_next;

    // Hit detection and victim choice: lowest invalid way wins over the pointer.
    always_comb begin
        hit          = 1'b0;
        hit_way      = '0;
        victim_found = 1'b0;
        victim_way   = rr_ptr[req_idx];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w] && !victim_found) begin
                victim_found = 1'b1;
                victim_way   = WAY_W'(w);
            end
        end
    end

    assign hit_line = data_q[req_idx][hit_way];
    assign hit_word = hit_line[{req_word, 5'b0} +: 32];

    always_comb begin
        merged_word = hit_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be_q[b]) begin
                merged_word[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    assign rr_next = (rr_ptr[req_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[req_idx] + 1'b1;

    always_comb begin
        scan_last = (scan_set == IDX_W'(SETS - 1)) && (scan_way == WAY_W'(WAYS - 1));
        if (scan_way == WAY_W'(WAYS - 1)) begin
            scan_way_next = '0;
            scan_set_next = scan_set + 1'b1;
        end else begin
            scan_way_next = scan_way + 1'b1;
            scan_set_next = scan_set;
        end
    end

    // The CPU response is combinational in TAG_CHECK so a hit completes one cycle after sampling.
    assign mem_resp  = (state == TAG_CHECK) && hit;
    assign mem_rdata = (mem_resp && !write_q) ? hit_word : rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            write_q      <= 1'b0;
            victim_q     <= '0;
            scan_set     <= '0;
            scan_way     <= '0;
            rdata_q      <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            flush_done_o <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            flush_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        addr_q  <= mem_address;
                        wdata_q <= mem_wdata;
                        be_q    <= mem_byte_enable;
                        write_q <= mem_write;
                        state   <= TAG_CHECK;
                    end else if (flush_i && !flush_done_o) begin
                        // The done pulse cycle is IDLE with flush_i still high; do not restart.
                        scan_set <= '0;
                        scan_way <= '0;
                        state    <= FLUSH_SCAN;
                    end
                end
                TAG_CHECK: begin
                    if (hit) begin
                        if (write_q) begin
                            data_q[req_idx][hit_way][{req_word, 5'b0} +: 32] <= merged_word;
                            dirty_q[req_idx][hit_way] <= 1'b1;
                        end else begin
                            rdata_q <= hit_word;
                        end
                        state <= IDLE;
                    end else begin
                        victim_q <= victim_way;
                        if (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) begin
                            pmem_write   <= 1'b1;
                            pmem_address <= {tag_q[req_idx][victim_way], req_idx, {OFF_W{1'b0}}};
                            pmem_wdata   <= data_q[req_idx][victim_way];
                            state        <= WRITEBACK;
                        end else begin
                            pmem_read    <= 1'b1;
                            pmem_address <= {req_tag, req_idx, {OFF_W{1'b0}}};
                            state        <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        pmem_write   <= 1'b0;
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        state        <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        pmem_read                  <= 1'b0;
                        data_q[req_idx][victim_q]  <= pmem_rdata;
                        tag_q[req_idx][victim_q]   <= req_tag;
                        valid_q[req_idx][victim_q] <= 1'b1;
                        dirty_q[req_idx][victim_q] <= 1'b0;
                        rr_ptr[req_idx]            <= rr_next;
                        state                      <= TAG_CHECK;
                    end
                end
                FLUSH_SCAN: begin
                    if (valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way]) begin
                        pmem_write   <= 1'b1;
                        pmem_address <= {tag_q[scan_set][scan_way], scan_set, {OFF_W{1'b0}}};
                        pmem_wdata   <= data_q[scan_set][scan_way];
                        state        <= FLUSH_WB;
                    end else if (scan_last) begin
                        flush_done_o <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        scan_set <= scan_set_next;
                        scan_way <= scan_way_next;
                    end
                end
                FLUSH_WB: begin
                    if (pmem_resp) begin
                        pmem_write                  <= 1'b0;
                        dirty_q[scan_set][scan_way] <= 1'b0;
                        if (scan_last) begin
                            flush_done_o <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            scan_set <= scan_set_next;
                            scan_way <= scan_way_next;
                            state    <= FLUSH_SCAN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
